aes_output_serializer: RTL and testbench

AES_OUTPUT_SERIALIZER -- requirements
Module: aes_output_serializer

---
 rtl/aes_output_serializer.sv | 101 ++++++++++
 tb/tb_aes_output_serializer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_output_serializer.sv
// Serializes an NBYTES ciphertext block MSB-byte first; first byte one cycle after capture, holds while dout_ready=0.
// Optional AES_OUT_PARITY_EN adds dout_parity (even-parity XOR of dout).
module aes_output_serializer #(
  parameter int NBYTES = 16
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  data_ok,
  input  logic [8*NBYTES-1:0]   ct_in,
  input  logic                  dout_ready,
  output logic [7:0]            dout,
  output logic                  dout_valid,
  output logic                  dout_last,
  output logic                  read_done,
  output logic                  busy
`ifdef AES_OUT_PARITY_EN
  ,
  output logic                  dout_parity
`endif
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [8*NBYTES-1:0] cap;
  logic                data_ok_q;
  logic                rise;

  assign rise = data_ok & ~data_ok_q;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] byte_at(input logic [8*NBYTES-1:0] blk,
                                         input logic [CW-1:0] idx);
    logic [8*NBYTES-1:0] sh;
    sh = blk << {idx, 3'b000};
    return sh[8*NBYTES-1 -: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      cnt        <= '0;
      cap        <= '0;
      data_ok_q  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      read_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_ok_q <= data_ok;
      case (state)
        IDLE: begin
          if (rise) begin
            cap   <= ct_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SEND;
          end
        end
        SEND: begin
          if (!dout_valid) begin
            dout       <= byte_at(cap, cnt);
            dout_valid <= 1'b1;
            dout_last  <= (cnt == LAST);
          end else if (dout_ready) begin
            if (cnt == LAST) begin
              dout       <= '0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
              read_done  <= 1'b1;
              state      <= DONE;
            end else begin
              cnt       <= cnt + 1'b1;
              dout      <= byte_at(cap, cnt + 1'b1);
              dout_last <= ((cnt + 1'b1) == LAST);
            end
          end
        end
        DONE: begin
          // Engine keeps data_ok high until it sees read_done; release once it drops.
          if (!data_ok) begin
            read_done <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_OUT_PARITY_EN
  assign dout_parity = ^dout;
`endif

endmodule

// File: tb/tb_aes_output_serializer.sv
// Directed bench for aes_output_serializer (NBYTES=16).
module tb_aes_output_serializer;
  logic         clk;
  logic         rst_;
  logic         data_ok;
  logic [127:0] ct_in;
  logic         dout_ready;
  logic [7:0]   dout;
  logic         dout_valid;
  logic         dout_last;
  logic         read_done;
  logic         busy;
`ifdef AES_OUT_PARITY_EN
  logic         dout_parity;
`endif

  int total = 0;
  int bad   = 0;

  aes_output_serializer #(.NBYTES(16)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .data_ok    (data_ok),
    .ct_in      (ct_in),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .read_done  (read_done),
    .busy       (busy)
`ifdef AES_OUT_PARITY_EN
    ,
    .dout_parity(dout_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk8({tag, "_dout"}, dout, 8'h00);
    chk1({tag, "_valid"}, dout_valid, 1'b0);
    chk1({tag, "_last"}, dout_last, 1'b0);
    chk1({tag, "_rdone"}, read_done, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  logic [127:0] ct_p;
  logic [127:0] ct_a;
  logic [127:0] ct_b;

  initial begin
    ct_p = 128'h00112233445566778899AABBCCDDEEFF;
    ct_a = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    ct_b = 128'h0102030405060708090A0B0C0D0E0F10;

    rst_       = 1'b0;
    data_ok    = 1'b0;
    ct_in      = '0;
    dout_ready = 1'b1;
    #1;
    chk_idle_outputs("reset");
    tick();
    rst_ = 1'b1;
    tick();
    chk_idle_outputs("idle_after_reset");

    // Basic block with continuous ready.
    ct_in   = ct_p;
    data_ok = 1'b1;
    tick();
    chk1("t1_busy_capture", busy, 1'b1);
    chk1("t1_valid_latency", dout_valid, 1'b0);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk1("t1_valid", dout_valid, 1'b1);
      chk8("t1_byte", dout, 8'(8'h11 * i));
      chk1("t1_last", dout_last, i == 15);
      tick();
    end
    chk1("t1_read_done", read_done, 1'b1);
    chk1("t1_done_valid", dout_valid, 1'b0);
    chk1("t1_done_busy", busy, 1'b1);
    data_ok = 1'b0;
    tick();
    chk1("t1_rdone_clear", read_done, 1'b0);
    chk1("t1_busy_clear", busy, 1'b0);
    tick();

    // Restart from byte 0, with a three-cycle stall on 0x33.
    data_ok = 1'b1;
    tick();
    tick();
    chk8("t2_restart_byte0", dout, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    chk8("t2_at_33", dout, 8'h33);
`ifdef AES_OUT_PARITY_EN
    chk1("t2_parity_33", dout_parity, 1'b0);
`endif
    dout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk8("t2_stall_dout", dout, 8'h33);
      chk1("t2_stall_valid", dout_valid, 1'b1);
      chk1("t2_stall_last", dout_last, 1'b0);
    end
    dout_ready = 1'b1;
    tick();
    chk8("t2_resume_44", dout, 8'h44);
    for (int i = 4; i < 16; i++) begin
      chk8("t2_byte", dout, 8'(8'h11 * i));
      tick();
    end
    chk1("t2_read_done", read_done, 1'b1);
    tick();
    tick();
    chk1("t2_read_done_hold", read_done, 1'b1);
    data_ok = 1'b0;
    tick();
    chk1("t2_rdone_clear", read_done, 1'b0);
    chk1("t2_busy_clear", busy, 1'b0);

    // Reset pulse after seven bytes.
    ct_in   = ct_b;
    data_ok = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      chk8("t3_byte", dout, 8'(i + 1));
`ifdef AES_OUT_PARITY_EN
      if (i == 6) chk1("t3_parity_07", dout_parity, 1'b1);
`endif
      tick();
    end
    chk8("t3_pre_reset_byte", dout, 8'h08);
    rst_    = 1'b0;
    data_ok = 1'b0;
    #1;
    chk_idle_outputs("t3_async_reset");
    tick();
    rst_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("t3_no_read_done", read_done, 1'b0);
      chk1("t3_no_busy", busy, 1'b0);
    end

    // data_ok already high when reset releases.
    rst_    = 1'b0;
    ct_in   = ct_p;
    data_ok = 1'b1;
    tick();
    rst_ = 1'b1;
    tick();
    chk1("t4_start_busy", busy, 1'b1);
    tick();
    chk1("t4_start_valid", dout_valid, 1'b1);
    chk8("t4_start_byte0", dout, 8'h00);
    for (int i = 0; i < 16; i++) tick();
    chk1("t4_read_done", read_done, 1'b1);
    data_ok = 1'b0;
    tick();
    chk1("t4_idle", busy, 1'b0);
    tick();

    // data_ok toggles and ct_in changes mid-block; data_ok ends low.
    ct_in   = ct_a;
    data_ok = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 16; i++) begin
      chk8("t5_byte", dout, ct_a[8*(15-i) +: 8]);
      chk1("t5_last", dout_last, i == 15);
      if (i == 2)  ct_in = ~ct_a;
      if (i == 3)  data_ok = 1'b0;
      if (i == 5)  data_ok = 1'b1;
      if (i == 10) data_ok = 1'b0;
      tick();
    end
    chk1("t5_read_done_pulse", read_done, 1'b1);
    tick();
    chk1("t5_read_done_one_cycle", read_done, 1'b0);
    chk1("t5_busy_clear", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
